// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arbiter_pkg;

    localparam int REG_SIZE = 32;   // address width
    localparam int WIDTH    = 128;  // one cache line

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_IC  = 2'd0,
        OWN_DCR = 2'd1,
        OWN_DCW = 2'd2
    } owner_e;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the three cache ports plus the memory command/response port.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = REG_SIZE,
    parameter int LINE_W = WIDTH
);
    logic              ic_read_req;
    logic [ADDR_W-1:0] ic_read_addr;
    logic [LINE_W-1:0] ic_read_data;
    logic              ic_read_ack;

    logic              dc_read_req;
    logic [ADDR_W-1:0] dc_read_addr;
    logic [LINE_W-1:0] dc_read_data;
    logic              dc_read_ack;

    logic              dc_write_req;
    logic [ADDR_W-1:0] dc_write_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_write_ack;

    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data_out;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data_in;

    // Arbiter side
    modport slave (
        input  ic_read_req, ic_read_addr,
        output ic_read_data, ic_read_ack,
        input  dc_read_req, dc_read_addr,
        output dc_read_data, dc_read_ack,
        input  dc_write_req, dc_write_addr, dc_write_data,
        output dc_write_ack,
        output mem_enable, mem_rw, mem_addr, mem_data_out,
        input  mem_ack, mem_data_in
    );

    // Caches + memory side
    modport master (
        output ic_read_req, ic_read_addr,
        input  ic_read_data, ic_read_ack,
        output dc_read_req, dc_read_addr,
        input  dc_read_data, dc_read_ack,
        output dc_write_req, dc_write_addr, dc_write_data,
        input  dc_write_ack,
        input  mem_enable, mem_rw, mem_addr, mem_data_out,
        output mem_ack, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter_arb_priority.sv
// Combinational grant select: DCW > DCR > IC, unless the Icache has been
// starved long enough, in which case a pending IC request wins outright.
module arb_priority
    import mem_arbiter_pkg::*;
(
    input  logic   ic_req_i,
    input  logic   dcr_req_i,
    input  logic   dcw_req_i,
    input  logic   starve_i,
    output logic   gnt_vld_o,
    output owner_e gnt_owner_o
);

    // Fixed priority with starvation override
    always_comb begin
        gnt_vld_o   = ic_req_i | dcr_req_i | dcw_req_i;
        gnt_owner_o = OWN_IC;
        if (starve_i && ic_req_i)
            gnt_owner_o = OWN_IC;
        else if (dcw_req_i)
            gnt_owner_o = OWN_DCW;
        else if (dcr_req_i)
            gnt_owner_o = OWN_DCR;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port memory arbiter: Icache fill, Dcache fill and Dcache write-back
// share a single memory port. IDLE picks an owner, BUSY holds the command
// until mem_ack, RESP pulses the owner's ack for one cycle. All outputs are
// registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = REG_SIZE,
    parameter int LINE_W     = WIDTH,
    parameter int STARVE_MAX = 2
)(
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              en_q, en_d;
    logic              rw_q, rw_d;
    logic [LINE_W-1:0] ic_data_q, ic_data_d;
    logic [LINE_W-1:0] dc_data_q, dc_data_d;
    logic              ic_ack_q, ic_ack_d;
    logic              dcr_ack_q, dcr_ack_d;
    logic              dcw_ack_q, dcw_ack_d;

    logic   gnt_vld;
    owner_e gnt_owner;

    arb_priority u_prio (
        .ic_req_i    (bus.ic_read_req),
        .dcr_req_i   (bus.dc_read_req),
        .dcw_req_i   (bus.dc_write_req),
        .starve_i    (starve_q == CNT_MAX),
        .gnt_vld_o   (gnt_vld),
        .gnt_owner_o (gnt_owner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; RESP always returns to IDLE so a held request
    // cannot be re-granted in the cycle its ack is visible
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt_vld)     state_d = ST_BUSY;
            ST_BUSY: if (bus.mem_ack) state_d = ST_RESP;
            ST_RESP:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Next values for every output/datapath register
    always_comb begin
        owner_d   = owner_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        en_d      = en_q;
        rw_d      = rw_q;
        ic_data_d = ic_data_q;
        dc_data_d = dc_data_q;
        ic_ack_d  = 1'b0;
        dcr_ack_d = 1'b0;
        dcw_ack_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Starvation counts only D-side wins over a waiting IC request
                if (!bus.ic_read_req || (gnt_vld && gnt_owner == OWN_IC))
                    starve_d = '0;
                else if (gnt_vld && starve_q != CNT_MAX)
                    starve_d = starve_q + CNT_W'(1);
                if (gnt_vld) begin
                    owner_d = gnt_owner;
                    en_d    = 1'b1;
                    case (gnt_owner)
                        OWN_DCW: begin
                            rw_d    = MEM_WRITE;
                            addr_d  = bus.dc_write_addr;
                            wdata_d = bus.dc_write_data;
                        end
                        OWN_DCR: begin
                            rw_d   = MEM_READ;
                            addr_d = bus.dc_read_addr;
                        end
                        default: begin
                            rw_d   = MEM_READ;
                            addr_d = bus.ic_read_addr;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (bus.mem_ack) begin
                    en_d = 1'b0;
                    case (owner_q)
                        OWN_DCW: dcw_ack_d = 1'b1;
                        OWN_DCR: begin
                            dcr_ack_d = 1'b1;
                            dc_data_d = bus.mem_data_in;
                        end
                        default: begin
                            ic_ack_d  = 1'b1;
                            ic_data_d = bus.mem_data_in;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Datapath/output registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= OWN_IC;
            starve_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            en_q      <= 1'b0;
            rw_q      <= MEM_READ;
            ic_data_q <= '0;
            dc_data_q <= '0;
            ic_ack_q  <= 1'b0;
            dcr_ack_q <= 1'b0;
            dcw_ack_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            ic_data_q <= ic_data_d;
            dc_data_q <= dc_data_d;
            ic_ack_q  <= ic_ack_d;
            dcr_ack_q <= dcr_ack_d;
            dcw_ack_q <= dcw_ack_d;
        end
    end

    assign bus.mem_enable   = en_q;
    assign bus.mem_rw       = rw_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_out = wdata_q;
    assign bus.ic_read_data = ic_data_q;
    assign bus.ic_read_ack  = ic_ack_q;
    assign bus.dc_read_data = dc_data_q;
    assign bus.dc_read_ack  = dcr_ack_q;
    assign bus.dc_write_ack = dcw_ack_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default `REG_SIZE (32), meaning request and memory address width.
REQ-002 SHALL have parameter LINE_W, default `WIDTH, meaning memory data width (one cache line).
REQ-003 SHALL have parameter STARVE_MAX, default 2, meaning the number of consecutive D-side grants allowed while ic_read_req waits.
REQ-004 clk  in  1  single clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ic_read_req / ic_read_addr / ic_read_data / ic_read_ack  in/in/out/out  1/ADDR_W/LINE_W/1  Icache line-fill port.
REQ-007 dc_read_req / dc_read_addr / dc_read_data / dc_read_ack  in/in/out/out  1/ADDR_W/LINE_W/1  Dcache line-fill port.
REQ-008 dc_write_req / dc_write_addr / dc_write_data / dc_write_ack  in/in/in/out  1/ADDR_W/LINE_W/1  Dcache write-back port.
REQ-009 mem_enable / mem_rw / mem_addr / mem_data_out  out  1/1/ADDR_W/LINE_W  memory command; mem_rw 1=write, 0=read.
REQ-010 mem_ack / mem_data_in  in  1/LINE_W  memory completion and read data.

Function
REQ-011 SHALL implement the FSM IDLE, BUSY, RESP, with registered grant owner in {IC, DCR, DCW}.
REQ-012 In IDLE with any request high, SHALL choose the owner: DCW > DCR > IC; IC wins instead if starve_cnt == STARVE_MAX.
REQ-013 When going IDLE->BUSY, SHALL latch the owner's addr (and, for DCW, data) and then drive mem_enable=1 with mem_addr, mem_rw and mem_data_out held stable for the whole of BUSY.
REQ-014 Latency SHALL be: request sampled high in IDLE at cycle N gives mem_enable=1 from cycle N+1.
REQ-015 In BUSY, SHALL wait indefinitely for mem_ack=1; at ack cycle M, go to RESP, and at M+1 drive mem_enable=0 and pulse the owner's ack=1 for exactly one cycle.
REQ-016 For a read owner, SHALL register mem_data_in at cycle M and present it on the owner's read_data from M+1; it is held until the next completion for that port.
REQ-017 RESP SHALL last one cycle, ignore all requests and return to IDLE; earliest next mem_enable is M+3.
REQ-018 starve_cnt: DCR/DCW grant while ic_read_req=1 increments (saturating at STARVE_MAX); IC grant or ic_read_req=0 in IDLE clears it.
REQ-019 Requesters SHALL hold req/addr/data stable until their ack; a request dropped while not owner is simply never granted; requests changing during BUSY do not affect the current transaction.
REQ-020 SHALL ignore mem_ack outside BUSY; only the owner port sees an ack, and at most one ack is high per cycle.
REQ-021 All outputs SHALL be driven from registers (no combinational req->mem path).

Reset
REQ-022 Reset SHALL force IDLE, starve_cnt=0, mem_enable=0, mem_rw=0, mem_addr=0, mem_data_out=0, all acks=0, all read_data=0, effective the cycle after reset is sampled.
REQ-023 Reset during BUSY or RESP SHALL abort the transaction without an ack; mem_ack in the same cycle as reset is ignored.

Structure
REQ-024 State encoding, owner encoding, and the mem_rw read/write constants SHALL be `defines in define.v; widths come from `REG_SIZE/`WIDTH.
REQ-025 A single sub-module arb_priority (combinational grant select from the three reqs plus the starve flag) is natural; the FSM and datapath live in mem_arbiter.

Verification
REQ-026 ic_read_req=1 only, addr 0x40, memory acks after 3 cycles with data 0xA5..A5 -> mem_enable 1 for cycles N+1..N+4, mem_rw=0, mem_addr=0x40; ic_read_ack pulse at ack+1 with ic_read_data=0xA5..A5.
REQ-027 dc_write_req (addr 0x100, data 0x1234) and dc_read_req (addr 0x200) raised in the same cycle -> write issued first (mem_rw=1, mem_addr=0x100, mem_data_out=0x1234), then the read at 0x200 starting 3 cycles after the write ack.
REQ-028 ic_read_req and dc_read_req held continuously, each new dc request raised right after its ack -> grant order DCR, DCR, IC, with starve_cnt reaching 2 then clearing.
REQ-029 reset asserted 2 cycles into BUSY, mem_ack=1 in the same cycle -> mem_enable=0 and no ack the next cycle, FSM in IDLE, outputs at reset values.
REQ-030 mem_ack pulsed while in IDLE with no requests -> no acks, mem_enable stays 0.
REQ-031 Requester keeps req high for 1 cycle after its ack -> no duplicate transaction (RESP blocks it); if req is still high in the following IDLE, a new grant is expected.
